// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB encodings, default-slave states and select-width helper.
package ahb_pkg;
  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_BUSY = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ = 2'b11;
  localparam logic HRESP_OKAY = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;
  typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_state_t;
  // The default slave is encoded as index NUM_SLAVES, so selects need one extra code.
  function automatic int sel_width(input int num_slaves);
    return $clog2(num_slaves + 1);
  endfunction
endpackage

// File: rtl/ahb_default_slave.sv
// ahb_default_slave: answers unmapped active transfers with a two-cycle ERROR.
module ahb_default_slave
  import ahb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic ready,
  output logic resp
);
  ds_state_t state;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= DS_IDLE;
      ready <= 1'b1;
      resp  <= HRESP_OKAY;
    end else if (state == DS_ERR1) begin
      state <= DS_ERR2;
      ready <= 1'b1;
      resp  <= HRESP_ERROR;
    end else begin
      state <= start ? DS_ERR1 : DS_IDLE;
      ready <= !start;
      resp  <= start ? HRESP_ERROR : HRESP_OKAY;
    end
  end
endmodule

// File: rtl/ahb_interconnect.sv
// ahb_interconnect: single-master AHB decoder, pipelined response mux,
// built-in default slave and error statistics.
module ahb_interconnect
  import ahb_pkg::*;
#(
  parameter int NUM_SLAVES  = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int REGION_BITS = 12
) (
  input  logic                         Hclk,
  input  logic                         Hresetn,
  input  logic [ADDR_W-1:0]            Haddr,
  input  logic [1:0]                   Htrans,
  output logic [NUM_SLAVES-1:0]        Hsel,
  output logic                         Hready,
  output logic                         Hresp,
  output logic [DATA_W-1:0]            Hrdata,
  input  logic [NUM_SLAVES*DATA_W-1:0] Hrdata_s,
  input  logic [NUM_SLAVES-1:0]        Hready_out_s,
  input  logic [NUM_SLAVES-1:0]        Hresp_s,
  output logic [15:0]                  err_count,
  output logic [ADDR_W-1:0]            err_addr
);
  localparam int SEL_W = sel_width(NUM_SLAVES);
  localparam logic [SEL_W-1:0] DEFAULT_SEL = SEL_W'(NUM_SLAVES);
  logic [ADDR_W-1:0] idx;
  logic              mapped;
  logic [SEL_W-1:0]  a_sel;
  logic [SEL_W-1:0]  d_sel;
  logic              d_act;
  logic [ADDR_W-1:0] d_addr;
  logic              ds_ready;
  logic              ds_resp;
  logic              s_ready;
  logic              s_resp;
  logic [DATA_W-1:0] s_rdata;
  assign idx    = Haddr >> REGION_BITS;
  assign mapped = idx < ADDR_W'(NUM_SLAVES);
  assign a_sel  = mapped ? idx[SEL_W-1:0] : DEFAULT_SEL;
  assign Hsel   = mapped ? NUM_SLAVES'(1) << a_sel : '0;
  ahb_default_slave u_default (
    .clk   (Hclk),
    .rst_n (Hresetn),
    .start (Hready && Htrans[1] && !mapped),
    .ready (ds_ready),
    .resp  (ds_resp)
  );
  always_comb begin
    s_ready = 1'b1;
    s_resp  = HRESP_OKAY;
    s_rdata = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (d_sel == SEL_W'(k)) begin
        s_ready = Hready_out_s[k];
        s_resp  = Hresp_s[k];
        s_rdata = Hrdata_s[k*DATA_W +: DATA_W];
      end
    end
  end
  assign Hready = !d_act ? 1'b1 : (d_sel == DEFAULT_SEL) ? ds_ready : s_ready;
  assign Hresp  = !d_act ? HRESP_OKAY : (d_sel == DEFAULT_SEL) ? ds_resp : s_resp;
  assign Hrdata = (d_act && d_sel != DEFAULT_SEL) ? s_rdata : '0;
  // Data-phase state only advances when the current data phase completes.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      d_sel     <= DEFAULT_SEL;
      d_act     <= 1'b0;
      d_addr    <= '0;
      err_count <= '0;
      err_addr  <= '0;
    end else begin
      if (Hready) begin
        d_sel  <= a_sel;
        d_act  <= Htrans[1];
        d_addr <= Haddr;
      end
      if (Hready && d_act && Hresp) begin
        err_count <= err_count + 16'(err_count != 16'hFFFF);
        err_addr  <= d_addr;
      end
    end
  end
endmodule

// File: doc/ahb_interconnect.md
# ahb_interconnect

Parametrised single-master AHB interconnect that replaces the fixed 4-slave decoder/multiplexer pair. It sits between the bus master and NUM_SLAVES slaves. It does three things: decodes Haddr into one-hot Hsel, registers the data-phase slave select so response muxing tracks the AHB address/data pipeline, and includes a built-in default slave that answers unmapped accesses with a two-cycle ERROR. It also records error statistics for debug.

## Interface
- NUM_SLAVES, 4, number of mapped slaves (1..16)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- REGION_BITS, 12, log2 of bytes per slave region; slave k owns [k<<REGION_BITS, (k+1)<<REGION_BITS)
- Hclk  in  1  bus clock, all state on rising edge
- Hresetn  in  1  asynchronous active-low reset
- Haddr  in  ADDR_W  master address-phase address
- Htrans  in  2  master transfer type (IDLE 00, BUSY 01, NONSEQ 10, SEQ 11)
- Hsel  out  NUM_SLAVES  one-hot slave select, combinational from Haddr
- Hready  out  1  bus ready, to master and broadcast to all slaves
- Hresp  out  1  muxed response to master (0 OKAY, 1 ERROR)
- Hrdata  out  DATA_W  muxed read data to master
- Hrdata_s  in  NUM_SLAVES*DATA_W  slave read data, slave k at [k*DATA_W +: DATA_W]
- Hready_out_s  in  NUM_SLAVES  per-slave ready
- Hresp_s  in  NUM_SLAVES  per-slave response
- err_count  out  16  saturating count of ERROR responses completed
- err_addr  out  ADDR_W  address of the most recent transfer that completed with ERROR

## Operation
- Decode: idx = Haddr >> REGION_BITS. If idx < NUM_SLAVES, Hsel[idx]=1. Otherwise Hsel=0 and the default slave is selected. Decode does not depend on Htrans.
- Data-phase register: on a rising edge with Hready=1, capture d_sel ← decoded target (slave index or DEFAULT), d_act ← Htrans[1] and d_addr ← Haddr. With Hready=0, all three hold.
- Response mux:
  - d_act=0: Hready=1, Hresp=0, Hrdata=0.
  - Mapped d_sel: Hready, Hresp and Hrdata come from slave d_sel.
  - DEFAULT: outputs come from the default slave; Hrdata=0.
- Default slave FSM, states DS_IDLE, DS_ERR1, DS_ERR2:
  - DS_IDLE→DS_ERR1 when Hready=1 and Htrans is NONSEQ or SEQ to an unmapped address.
  - DS_ERR1→DS_ERR2 unconditionally. DS_ERR2→DS_IDLE, or →DS_ERR1 if a new unmapped NONSEQ/SEQ is presented.
  - Outputs: DS_ERR1 Hready=0 Hresp=1; DS_ERR2 Hready=1 Hresp=1; DS_IDLE Hready=1 Hresp=0.
- IDLE/BUSY to an unmapped address completes with a zero-wait OKAY.
- Error logging: on any rising edge where the data phase completes (Hready=1, d_act=1, Hresp=1), err_count increments, saturating at 16'hFFFF, and err_addr ← d_addr. This covers both slave and default-slave errors.

## Timing
- Reset values: d_act=0, d_sel=DEFAULT, FSM=DS_IDLE, Hready=1, Hresp=0, Hrdata=0, err_count=0, err_addr=0. Hsel follows Haddr combinationally.
- Hsel: zero latency from Haddr.
- Data phase: exactly one cycle after the address phase, extended by slave wait states. Slave Hready_out reaches Hready combinationally with no added latency.
- Slave wait states (Hready_out=0) freeze the data-phase register. A new address is not accepted until Hready=1.
- Back-to-back transfers to different slaves: the mux switches on the edge where Hready=1, with no bubble.
- Unmapped access: ERROR is seen for exactly 2 data-phase cycles (low-ready then high-ready).
- Asynchronous reset mid-transfer: all state returns to reset values immediately, and the aborted transfer is not counted.
- Two errors completing on consecutive edges count as 2.

## Structure
- Package ahb_pkg holds:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ and HRESP_OKAY/ERROR constants.
  - The default-slave state enum.
  - The DEFAULT select encoding: value NUM_SLAVES, with select width $clog2(NUM_SLAVES+1).
- One sub-module, ahb_default_slave, contains the 3-state FSM. Decode, the data-phase register, the mux and logging stay in the top.

## Test plan
- Reset asserted with Htrans=NONSEQ, Haddr=0x1000 → Hready=1, Hresp=0, Hrdata=0, err_count=0; Hsel=4'b0010 combinationally.
- NONSEQ read 0x2004, slave 2 returns 0xDEADBEEF with 2 wait states → Hready low for 2 cycles, then Hrdata=0xDEADBEEF, Hresp=0.
- Back-to-back NONSEQ to 0x0000 then 0x3000 → data phases muxed from slave 0 then slave 3 on consecutive cycles.
- NONSEQ to 0x5000 with NUM_SLAVES=4 → Hsel=0, Hready 0 then 1 with Hresp=1 both cycles; err_count=1, err_addr=0x5000.
- IDLE to 0x5000 → zero-wait OKAY, err_count unchanged.
- Force 65537 errors → err_count saturates at 0xFFFF; Hresetn pulsed mid-ERR1 → FSM returns to DS_IDLE and Hready=1 immediately.
